elp_tracker: RTL and testbench

ELP_TRACKER -- requirements
Module: elp_tracker

---
 rtl/elp_tracker_if.sv | 36 +++
 rtl/elp_tracker.sv | 119 +++++++++++
 tb/tb_elp_tracker.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/elp_tracker_if.sv
// Commit-side bus of the ELP tracker, plus the shared ELP and exception types
// that the tracker and its neighbours exchange.

interface elp_tracker_if #(
  parameter int unsigned LABEL_W = 20
);
  logic               commit_valid_i;
  logic               commit_is_ijump_i;
  logic [4:0]         commit_rs1_i;
  logic [LABEL_W-1:0] x7_label_i;
  logic [1:0]         complete_cfi_i;

  modport master (
    output commit_valid_i, commit_is_ijump_i, commit_rs1_i, x7_label_i, complete_cfi_i
  );
  modport slave (
    input  commit_valid_i, commit_is_ijump_i, commit_rs1_i, x7_label_i, complete_cfi_i
  );
endinterface

package riscv;
  typedef enum logic {
    NO_LP_EXPECTED = 1'b0,
    LP_EXPECTED    = 1'b1
  } elp;

  localparam logic [63:0] SW_CHECK = 64'd18;
endpackage

package ariane_pkg;
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;
endpackage

// File: rtl/elp_tracker.sv
// Zicfilp expected-landing-pad tracker: arms on an indirect JALR, checks the
// landing pad at the target, and raises a software-check fault on violation.

module elp_tracker #(
  parameter int unsigned LABEL_W = 20,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   xlpad_i,
  input  logic                   debug_mode_i,
  elp_tracker_if.slave           commit_if,
  input  logic                   trap_i,
  input  logic                   xret_i,
  output riscv::elp              elp_o,
  output logic [LABEL_W-1:0]     label_o,
  output riscv::elp              prev_elp_o,
  output ariane_pkg::exception_t fault_o,
  output logic [CNT_W-1:0]       viol_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPECT = 2'd1,
    S_FAULT  = 2'd2
  } state_e;

  localparam logic [1:0] CFI_PASS = 2'b11;
  localparam logic [63:0] LPAD_TVAL = 64'd2;

  state_e             state_q,    state_d;
  logic [LABEL_W-1:0] label_q,    label_d;
  riscv::elp          prev_elp_q, prev_elp_d;
  logic [CNT_W-1:0]   viol_cnt_q, viol_cnt_d;

  logic      jalr_commit;
  logic      link_rs1;
  riscv::elp cur_elp;

  assign jalr_commit = commit_if.commit_valid_i & commit_if.commit_is_ijump_i;
  // x1/x5/x7 as rs1 mark returns and software-guarded calls, which never arm.
  assign link_rs1    = commit_if.commit_rs1_i inside {5'd1, 5'd5, 5'd7};
  assign cur_elp     = (state_q == S_IDLE) ? riscv::NO_LP_EXPECTED : riscv::LP_EXPECTED;

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst_i) begin
      state_q    <= S_IDLE;
      label_q    <= '0;
      prev_elp_q <= riscv::NO_LP_EXPECTED;
      viol_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      label_q    <= label_d;
      prev_elp_q <= prev_elp_d;
      viol_cnt_q <= viol_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: hold-by-default assignments up front prevent latch inference.
    state_d    = state_q;
    label_d    = label_q;
    prev_elp_d = prev_elp_q;
    viol_cnt_d = viol_cnt_q;

    if (debug_mode_i) begin
      state_d = state_q;
    end else if (trap_i) begin
      prev_elp_d = cur_elp;
      state_d    = S_IDLE;
    end else if (xret_i) begin
      state_d    = (prev_elp_q == riscv::LP_EXPECTED && xlpad_i) ? S_EXPECT : S_IDLE;
      prev_elp_d = riscv::NO_LP_EXPECTED;
    end else if (!xlpad_i) begin
      // A pending fault still has to be taken as a trap.
      if (state_q != S_FAULT) state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (jalr_commit && !link_rs1) begin
            state_d = S_EXPECT;
            label_d = commit_if.x7_label_i;
          end
        end
        S_EXPECT: begin
          if (commit_if.commit_valid_i) begin
            if (commit_if.complete_cfi_i == CFI_PASS && !commit_if.commit_is_ijump_i) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_FAULT;
              if (viol_cnt_q != '1) viol_cnt_d = viol_cnt_q + CNT_W'(1);
            end
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    fault_o = '0;
    elp_o   = cur_elp;
    if (state_q == S_FAULT) begin
      fault_o.valid = 1'b1;
      fault_o.cause = riscv::SW_CHECK;
      fault_o.tval  = LPAD_TVAL;
    end
  end

  assign label_o    = label_q;
  assign prev_elp_o = prev_elp_q;
  assign viol_cnt_o = viol_cnt_q;

endmodule

// File: tb/tb_elp_tracker.sv
// Directed bench for elp_tracker: a default-width instance and a CNT_W=2
// instance share one commit bus and all control inputs.

module tb_elp_tracker;

  logic clk = 1'b0;
  logic rst, xlpad, dbg, trap, xret;

  riscv::elp              elp, prev_elp, elp_s, prev_elp_s;
  logic [19:0]            label, label_s;
  ariane_pkg::exception_t fault, fault_s;
  logic [15:0]            cnt;
  logic [1:0]             cnt_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  elp_tracker_if #(.LABEL_W(20)) cif ();

  elp_tracker #(.LABEL_W(20), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .xlpad_i(xlpad), .debug_mode_i(dbg),
    .commit_if(cif.slave), .trap_i(trap), .xret_i(xret),
    .elp_o(elp), .label_o(label), .prev_elp_o(prev_elp),
    .fault_o(fault), .viol_cnt_o(cnt)
  );

  elp_tracker #(.LABEL_W(20), .CNT_W(2)) dut_small (
    .clk_i(clk), .rst_i(rst), .xlpad_i(xlpad), .debug_mode_i(dbg),
    .commit_if(cif.slave), .trap_i(trap), .xret_i(xret),
    .elp_o(elp_s), .label_o(label_s), .prev_elp_o(prev_elp_s),
    .fault_o(fault_s), .viol_cnt_o(cnt_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cif.commit_valid_i    = 1'b0;
    cif.commit_is_ijump_i = 1'b0;
    cif.commit_rs1_i      = 5'd0;
    cif.x7_label_i        = 20'h0;
    cif.complete_cfi_i    = 2'b01;
    trap = 1'b0;
    xret = 1'b0;
  endtask

  task automatic jalr(input logic [4:0] rs1, input logic [19:0] lbl);
    cif.commit_valid_i    = 1'b1;
    cif.commit_is_ijump_i = 1'b1;
    cif.commit_rs1_i      = rs1;
    cif.x7_label_i        = lbl;
    step();
    idle_bus();
  endtask

  task automatic land(input logic [1:0] cfi);
    cif.commit_valid_i = 1'b1;
    cif.complete_cfi_i = cfi;
    step();
    idle_bus();
  endtask

  task automatic pulse_trap();
    trap = 1'b1;
    step();
    idle_bus();
  endtask

  initial begin
    rst = 1'b1; xlpad = 1'b1; dbg = 1'b0;
    idle_bus();
    step();
    step();
    rst = 1'b0;

    check("rst_elp",   elp, riscv::NO_LP_EXPECTED);
    check("rst_prev",  prev_elp, riscv::NO_LP_EXPECTED);
    check("rst_label", label, 20'h0);
    check("rst_fault", fault.valid, 1'b0);
    check("rst_cnt",   cnt, 16'd0);

    // Arm through rs1=6, then land on a passing pad
    jalr(5'd6, 20'h12345);
    check("arm_elp",   elp, riscv::LP_EXPECTED);
    check("arm_label", label, 20'h12345);
    check("arm_fault", fault.valid, 1'b0);
    land(2'b11);
    check("pass_elp",  elp, riscv::NO_LP_EXPECTED);
    check("pass_cnt",  cnt, 16'd0);

    // Link registers never arm and never load the label
    for (int i = 0; i < 3; i++) begin
      logic [4:0] rs;
      rs = (i == 0) ? 5'd1 : (i == 1) ? 5'd5 : 5'd7;
      jalr(rs, 20'hABCDE);
      check($sformatf("link%0d_elp", rs), elp, riscv::NO_LP_EXPECTED);
      check($sformatf("link%0d_label", rs), label, 20'h12345);
    end

    // Label mismatch: fault held across idle cycles until the trap
    jalr(5'd6, 20'h00777);
    check("arm2_elp", elp, riscv::LP_EXPECTED);
    land(2'b00);
    for (int i = 0; i < 3; i++) begin
      check("fault_valid", fault.valid, 1'b1);
      check("fault_cause", fault.cause, 64'd18);
      check("fault_tval",  fault.tval, 64'd2);
      check("fault_elp",   elp, riscv::LP_EXPECTED);
      step();
    end
    check("fault_cnt", cnt, 16'd1);
    pulse_trap();
    check("trap_elp",   elp, riscv::NO_LP_EXPECTED);
    check("trap_prev",  prev_elp, riscv::LP_EXPECTED);
    check("trap_valid", fault.valid, 1'b0);
    check("trap_cause", fault.cause, 64'd0);
    check("trap_tval",  fault.tval, 64'd0);
    check("trap_cnt",   cnt, 16'd1);
    check("trap_label", label, 20'h00777);

    // Trap then xret restores the expectation
    xret = 1'b1;
    step();
    idle_bus();
    land(2'b11);
    jalr(5'd10, 20'h00042);
    pulse_trap();
    check("t2_elp",  elp, riscv::NO_LP_EXPECTED);
    check("t2_prev", prev_elp, riscv::LP_EXPECTED);
    xret = 1'b1;
    step();
    idle_bus();
    check("xret_elp",   elp, riscv::LP_EXPECTED);
    check("xret_prev",  prev_elp, riscv::NO_LP_EXPECTED);
    check("xret_label", label, 20'h00042);
    land(2'b11);
    check("xret_land", elp, riscv::NO_LP_EXPECTED);

    // Same, with enforcement off at xret
    jalr(5'd10, 20'h00042);
    pulse_trap();
    xlpad = 1'b0;
    xret  = 1'b1;
    step();
    idle_bus();
    xlpad = 1'b1;
    check("xret_off_elp",  elp, riscv::NO_LP_EXPECTED);
    check("xret_off_prev", prev_elp, riscv::NO_LP_EXPECTED);

    // Trap beats a simultaneous arming JALR
    trap = 1'b1;
    jalr(5'd6, 20'h55555);
    check("trapjalr_elp",   elp, riscv::NO_LP_EXPECTED);
    check("trapjalr_prev",  prev_elp, riscv::NO_LP_EXPECTED);
    check("trapjalr_label", label, 20'h00042);

    // Idle branch unit while expecting is a violation
    jalr(5'd6, 20'h00100);
    land(2'b01);
    check("idle_cfi_fault", fault.valid, 1'b1);
    check("idle_cfi_cnt",   cnt, 16'd2);
    pulse_trap();

    // A second JALR while expecting faults instead of re-arming
    jalr(5'd6, 20'h00200);
    cif.complete_cfi_i = 2'b11;
    jalr(5'd6, 20'h00300);
    check("rearm_fault", fault.valid, 1'b1);
    check("rearm_label", label, 20'h00200);
    check("rearm_cnt",   cnt, 16'd3);
    pulse_trap();

    // Enforcement off drops an expectation without a fault
    jalr(5'd6, 20'h00400);
    xlpad = 1'b0;
    step();
    xlpad = 1'b1;
    check("xoff_elp",   elp, riscv::NO_LP_EXPECTED);
    check("xoff_fault", fault.valid, 1'b0);
    check("xoff_cnt",   cnt, 16'd3);

    // Debug mode freezes state and label
    dbg = 1'b1;
    jalr(5'd6, 20'h00500);
    dbg = 1'b0;
    check("dbg_elp",   elp, riscv::NO_LP_EXPECTED);
    check("dbg_label", label, 20'h00400);

    // Fresh counters, five faults: wide counter counts, narrow one saturates
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      jalr(5'd6, 20'(i + 1));
      land(2'b10);
      check($sformatf("loop%0d_fault", i), fault.valid, 1'b1);
      if (i < 4) pulse_trap();
    end
    check("sat_cnt_small", cnt_s, 2'd3);
    check("sat_cnt_wide",  cnt, 16'd5);
    check("sat_fault_s",   fault_s.valid, 1'b1);

    // Reset mid-fault wins over trap and commit on the same edge
    rst  = 1'b1;
    trap = 1'b1;
    jalr(5'd6, 20'hFFFFF);
    rst = 1'b0;
    check("rstf_elp",     elp, riscv::NO_LP_EXPECTED);
    check("rstf_prev",    prev_elp, riscv::NO_LP_EXPECTED);
    check("rstf_label",   label, 20'h0);
    check("rstf_valid",   fault.valid, 1'b0);
    check("rstf_cause",   fault.cause, 64'd0);
    check("rstf_cnt",     cnt, 16'd0);
    check("rstf_cnt_s",   cnt_s, 2'd0);
    check("rstf_valid_s", fault_s.valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
